// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external 16-bit ALU: fetch, decode, operand read, execute, writeback.
// Ports: clk, reset, s/in_instr/w (start), illegal, Ain/Bin/ALUop/alu_out/alu_Z, status, dp_out. Option: ALU_SEQ_SHIFTER_EN.
module alu_sequencer #(
  parameter int               DATA_W    = 16,
  parameter logic [DATA_W-1:0] REG_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in_instr,
  output logic              w,
  output logic              illegal,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [1:0]        ALUop,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_Z,
  output logic [2:0]        status,
  output logic [DATA_W-1:0] dp_out
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WRITE,
    S_WIMM
  } state_t;

  state_t state, nxt;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, c;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] rm_val, b_sh, imm_ext;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op;
  logic       is_imm, is_mov, is_alu, is_cmp;

  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign rm  = ir[2:0];

  assign is_imm = (opc == 3'b110) && (op == 2'b10);
  assign is_mov = (opc == 3'b110) && (op == 2'b00);
  assign is_alu = (opc == 3'b101);
  assign is_cmp = is_alu && (op == 2'b01);

  assign imm_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign rm_val  = rf[rm];

`ifdef ALU_SEQ_SHIFTER_EN
  logic [1:0] sh;
  assign sh = ir[4:3];

  always_comb begin
    b_sh = rm_val;
    unique case (sh)
      2'b01:   b_sh = {rm_val[DATA_W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, rm_val[DATA_W-1:1]};
      2'b11:   b_sh = {rm_val[DATA_W-1],
                       rm_val[DATA_W-1:1]};
      default: b_sh = rm_val;
    endcase
  end
`else
  assign b_sh = rm_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    illegal = 1'b0;
    unique case (state)
      S_WAIT:   if (s) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_imm:  nxt = S_WIMM;
          is_mov:  nxt = S_GETB;
          is_alu:  nxt = S_GETA;
          default: begin
            illegal = 1'b1;
            nxt     = S_WAIT;
          end
        endcase
      end
      S_GETA:  nxt = S_GETB;
      S_GETB:  nxt = S_EXEC;
      S_EXEC:  nxt = is_cmp ? S_WAIT : S_WRITE;
      S_WRITE: nxt = S_WAIT;
      S_WIMM:  nxt = S_WAIT;
      default: nxt = S_WAIT;
    endcase
  end

  // MOV reg passes B through the ALU as 0 + B.
  always_comb begin
    Ain   = '0;
    Bin   = '0;
    ALUop = 2'b00;
    if (state == S_EXEC) begin
      Bin = b;
      if (is_alu) begin
        Ain   = a;
        ALUop = op;
      end
    end
  end

  assign w      = (state == S_WAIT);
  assign dp_out = c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      c      <= REG_RESET;
      status <= 3'b000;
      for (int i = 0; i < 8; i++)
        rf[i] <= REG_RESET;
    end else begin
      unique case (state)
        S_WAIT:  if (s) ir <= in_instr;
        S_GETA:  a <= rf[rn];
        S_GETB:  b <= b_sh;
        S_EXEC: begin
          c <= alu_out;
          if (is_cmp) status <= alu_Z;
        end
        S_WRITE: rf[rd] <= c;
        S_WIMM:  rf[rn] <= imm_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer with a behavioural ALU and reference model.
// Ports of the DUT are all driven/observed here; the ALU itself is modelled combinationally.
module tb_alu_sequencer;

  localparam int W = 16;

`ifdef ALU_SEQ_SHIFTER_EN
  localparam bit SH_ON = 1'b1;
`else
  localparam bit SH_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         s;
  logic [15:0]  in_instr;
  logic         w, illegal;
  logic [W-1:0] Ain, Bin, alu_out, dp_out;
  logic [1:0]   ALUop;
  logic [2:0]   alu_Z, status;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(W), .REG_RESET('0)) dut (
    .clk(clk), .reset(reset), .s(s), .in_instr(in_instr),
    .w(w), .illegal(illegal), .Ain(Ain), .Bin(Bin),
    .ALUop(ALUop), .alu_out(alu_out), .alu_Z(alu_Z),
    .status(status), .dp_out(dp_out)
  );

  logic [W-1:0] r;
  logic         v;
  always_comb begin
    v = 1'b0;
    case (ALUop)
      2'b00: begin
        r = Ain + Bin;
        v = (Ain[W-1] == Bin[W-1]) && (r[W-1] != Ain[W-1]);
      end
      2'b01: begin
        r = Ain - Bin;
        v = (Ain[W-1] != Bin[W-1]) && (r[W-1] != Ain[W-1]);
      end
      2'b10:   r = Ain & Bin;
      default: r = ~Bin;
    endcase
    alu_out = r;
    alu_Z   = {r[W-1], v, r == '0};
  end

  logic [W-1:0] m_rf [8];
  logic [W-1:0] m_c;
  logic [2:0]   m_st;
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mshift(input logic [1:0] sh,
                                          input logic [W-1:0] x);
    logic [W-1:0] y;
    case (sh)
      2'd1:    y = W'(x * 2);
      2'd2:    y = x / 2;
      2'd3:    y = W'($signed(x) >>> 1);
      default: y = x;
    endcase
    return SH_ON ? y : x;
  endfunction

  function automatic logic [15:0] mov_imm(input logic [2:0] rn,
                                          input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction

  function automatic logic [15:0] mov_reg(input logic [2:0] rd,
                                          input logic [2:0] rm,
                                          input logic [1:0] sh);
    return {3'b110, 2'b00, 3'b000, rd, sh, rm};
  endfunction

  function automatic logic [15:0] alu(input logic [1:0] op,
                                      input logic [2:0] rn,
                                      input logic [2:0] rd,
                                      input logic [2:0] rm,
                                      input logic [1:0] sh);
    return {3'b101, op, rn, rd, sh, rm};
  endfunction

  function automatic bit legal(input logic [15:0] ins);
    return (ins[15:13] == 3'b101) ||
           (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) ||
           (ins[15:13] == 3'b110 && ins[12:11] == 2'b00);
  endfunction

  task automatic model(input logic [15:0] ins, output int lat,
                       output logic ill);
    logic [W-1:0] a, b, res;
    int sres;
    ill = 1'b0;
    lat = 2;
    if (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) begin
      m_rf[ins[10:8]] = W'($signed(ins[7:0]));
      lat = 3;
    end else if (ins[15:13] == 3'b110 && ins[12:11] == 2'b00) begin
      res = mshift(ins[4:3], m_rf[ins[2:0]]);
      m_c = res;
      m_rf[ins[7:5]] = res;
      lat = 5;
    end else if (ins[15:13] == 3'b101) begin
      a = m_rf[ins[10:8]];
      b = mshift(ins[4:3], m_rf[ins[2:0]]);
      case (ins[12:11])
        2'd0:    res = a + b;
        2'd1:    res = a - b;
        2'd2:    res = a & b;
        default: res = ~b;
      endcase
      m_c = res;
      if (ins[12:11] == 2'd1) begin
        sres = int'($signed(a)) - int'($signed(b));
        m_st = {res[W-1], (sres > 32767 || sres < -32768),
                res == '0};
        lat = 5;
      end else begin
        m_rf[ins[7:5]] = res;
        lat = 6;
      end
    end else begin
      ill = 1'b1;
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the
  // falling edge where w is seen high again.
  task automatic run(input logic [15:0] ins, input bit hold);
    int lat, cyc, nill;
    logic ill, il1;
    model(ins, lat, ill);
    check("w_idle", w, 1);
    in_instr = ins;
    s = 1'b1;
    @(negedge clk);
    cyc = 1;
    nill = 0;
    il1 = illegal;
    if (hold) in_instr = 16'hE000;
    else      s = 1'b0;
    while (!w && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (illegal) nill++;
    end
    check("latency", cyc, lat);
    check("illegal", il1, ill);
    check("illegal_late", nill, 0);
    check("dp_out", dp_out, m_c);
    check("status", status, m_st);
  endtask

  task automatic rdreg(input logic [2:0] x, input logic [W-1:0] exp);
    run(mov_reg(x, x, 2'b00), 1'b0);
    check("reg_read", dp_out, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_c  = '0;
    m_st = 3'b000;
  endtask

  initial begin
    logic [15:0] ins;
    int k;
    reset = 1'b1;
    s = 1'b0;
    in_instr = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_w", w, 1);
    check("rst_illegal", illegal, 0);
    check("rst_status", status, 0);
    check("rst_dp", dp_out, 0);
    check("rst_ain", Ain, 0);
    check("rst_bin", Bin, 0);
    check("rst_aluop", ALUop, 0);
    reset = 1'b0;
    @(negedge clk);

    run(mov_imm(3'd0, 8'h05), 1'b0);
    run(mov_imm(3'd1, 8'hFD), 1'b0);
    rdreg(3'd0, 16'h0005);
    rdreg(3'd1, 16'hFFFD);

    run(alu(2'd0, 3'd0, 3'd2, 3'd1, 2'd0), 1'b0);
    check("add_dp", dp_out, 16'h0002);
    check("add_status", status, 3'b000);

    run(alu(2'd1, 3'd0, 3'd0, 3'd0, 2'd0), 1'b0);
    check("cmp_eq", status, 3'b001);
    run(alu(2'd1, 3'd1, 3'd0, 3'd0, 2'd0), 1'b0);
    check("cmp_neg", status, 3'b100);
    rdreg(3'd0, 16'h0005);

    run(mov_imm(3'd3, 8'h80), 1'b0);
    repeat (8) run(alu(2'd0, 3'd3, 3'd3, 3'd3, 2'd0), 1'b0);
    run(alu(2'd3, 3'd0, 3'd3, 3'd3, 2'd0), 1'b0);
    check("r3_7fff", dp_out, 16'h7FFF);
    run(mov_imm(3'd4, 8'h01), 1'b0);
    run(alu(2'd1, 3'd3, 3'd0, 3'd1, 2'd0), 1'b0);
    check("cmp_ovf", status, 3'b110);
    run(alu(2'd3, 3'd0, 3'd5, 3'd4, 2'd0), 1'b0);
    check("mvn", dp_out, 16'hFFFE);
    run(alu(2'd2, 3'd3, 3'd6, 3'd4, 2'd0), 1'b0);
    check("and", dp_out, 16'h0001);

    run(16'hE000, 1'b0);
    run(mov_imm(3'd2, 8'h11), 1'b1);
    run(mov_imm(3'd6, 8'h22), 1'b1);
    s = 1'b0;
    rdreg(3'd2, 16'h0011);
    rdreg(3'd6, 16'h0022);

    run(mov_reg(3'd7, 3'd1, 2'b11), 1'b0);
`ifdef ALU_SEQ_SHIFTER_EN
    check("r7_asr", dp_out, 16'hFFFE);
`else
    check("r7_asr", dp_out, 16'hFFFD);
`endif

    in_instr = alu(2'd0, 3'd0, 3'd2, 3'd1, 2'd0);
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("midrst_w", w, 1);
    @(negedge clk);
    check("midrst_status", status, 0);
    check("midrst_dp", dp_out, 0);
    check("midrst_illegal", illegal, 0);
    clear_model();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rdreg(3'(i), '0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3)
        ins = mov_imm(3'($urandom), 8'($urandom));
      else if (k < 5)
        ins = mov_reg(3'($urandom), 3'($urandom), 2'($urandom));
      else if (k < 9)
        ins = alu(2'($urandom), 3'($urandom), 3'($urandom),
                  3'($urandom), 2'($urandom));
      else begin
        ins = 16'($urandom);
        while (legal(ins)) ins = 16'($urandom);
      end
      run(ins, bit'($urandom_range(0, 3) == 0));
      s = 1'b0;
    end

    for (int i = 0; i < 8; i++) rdreg(3'(i), m_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
